// File: rtl/uart_cmd_bridge.sv
// Host command parser between uart_rx/uart_tx and the DSP register file / APU RAM.
// Each command produces DSP/RAM side effects and exactly one reply byte.
module uart_cmd_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1843200,
    parameter int unsigned READ_LATENCY   = 2,
    parameter int unsigned RESET_CYCLES   = 16,
    parameter logic [7:0]  ACK_BYTE       = 8'hAA,
    parameter logic [7:0]  NAK_BYTE       = 8'hEE,
    parameter logic [7:0]  PING_BYTE      = 8'h5A
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_uart_byte,
    input  logic        in_uart_byte_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_write,
    input  logic        tx_ready,
    output logic [7:0]  dsp_reg_address,
    output logic [7:0]  dsp_reg_data_in,
    output logic        dsp_reg_write_enable,
    input  logic [7:0]  dsp_reg_data_out,
    output logic [15:0] ram_address,
    output logic [7:0]  ram_data,
    output logic        ram_write_enable,
    output logic        dsp_reset,
    output logic        overrun,
    output logic        busy
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StArg    = 3'd1;
    localparam logic [2:0] StExec   = 3'd2;
    localparam logic [2:0] StRdWait = 3'd3;
    localparam logic [2:0] StRst    = 3'd4;
    localparam logic [2:0] StSend   = 3'd5;
    localparam logic [2:0] StGuard  = 3'd6;

    localparam logic [7:0] OpRegWr  = 8'h01;
    localparam logic [7:0] OpRegRd  = 8'h02;
    localparam logic [7:0] OpRamWr  = 8'h03;
    localparam logic [7:0] OpDspRst = 8'h04;
    localparam logic [7:0] OpPing   = 8'h05;

    localparam logic [20:0] TimeoutLast = 21'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  RdLast      = 8'(READ_LATENCY - 1);
    localparam logic [7:0]  RstLast     = 8'(RESET_CYCLES - 1);
    localparam logic [7:0]  GuardLast   = 8'd1;

    logic [2:0]  state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  arg_q [3];
    logic [7:0]  arg_d [3];
    logic [20:0] timeout_q, timeout_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  reply_q, reply_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  reg_data_q, reg_data_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_data_q, ram_data_d;
    logic        start_cmd;
    logic        exec_reg_wr, exec_reg_rd, exec_ram_wr;

    function automatic logic [1:0] num_args(input logic [7:0] op);
        case (op)
            OpRegWr: return 2'd2;
            OpRegRd: return 2'd1;
            OpRamWr: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        idx_d      = idx_q;
        arg_d      = arg_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
        reply_d    = reply_q;
        overrun_d  = overrun_q;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        start_cmd  = 1'b0;

        case (state_q)
            StIdle: start_cmd = in_uart_byte_ready;
            StArg: begin
                if (timeout_q == TimeoutLast) begin
                    // Expiry drops the partial command; a coincident byte opens the next one
                    state_d   = StIdle;
                    timeout_d = '0;
                    start_cmd = in_uart_byte_ready;
                end else if (in_uart_byte_ready) begin
                    for (int i = 0; i < 3; i++) begin
                        if (idx_q == 2'(i)) arg_d[i] = in_uart_byte;
                    end
                    idx_d     = idx_q + 2'd1;
                    timeout_d = '0;
                    if (idx_q == num_args(op_q) - 2'd1) state_d = StExec;
                end else begin
                    timeout_d = timeout_q + 21'd1;
                end
            end
            StExec: begin
                state_d = StSend;
                case (op_q)
                    OpRegWr: begin
                        reg_addr_d = arg_q[0];
                        reg_data_d = arg_q[1];
                        reply_d    = ACK_BYTE;
                    end
                    OpRegRd: begin
                        reg_addr_d = arg_q[0];
                        cnt_d      = '0;
                        state_d    = StRdWait;
                    end
                    OpRamWr: begin
                        ram_addr_d = {arg_q[0], arg_q[1]};
                        ram_data_d = arg_q[2];
                        reply_d    = ACK_BYTE;
                    end
                    OpDspRst: begin
                        cnt_d   = '0;
                        state_d = StRst;
                    end
                    OpPing:  reply_d = PING_BYTE;
                    default: reply_d = NAK_BYTE;
                endcase
            end
            StRdWait: begin
                if (cnt_q == RdLast) begin
                    reply_d = dsp_reg_data_out;
                    state_d = StSend;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StRst: begin
                if (cnt_q == RstLast) begin
                    reply_d = ACK_BYTE;
                    state_d = StSend;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StSend: begin
                if (tx_ready) begin
                    cnt_d   = '0;
                    state_d = StGuard;
                end
            end
            StGuard: begin
                if (cnt_q == GuardLast) state_d = StIdle;
                else cnt_d = cnt_q + 8'd1;
            end
            default: state_d = StIdle;
        endcase

        if (start_cmd) begin
            op_d      = in_uart_byte;
            idx_d     = '0;
            timeout_d = '0;
            state_d   = (num_args(in_uart_byte) != 2'd0) ? StArg : StExec;
        end

        if (in_uart_byte_ready && state_q != StIdle && state_q != StArg) overrun_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= '0;
            idx_q      <= '0;
            for (int i = 0; i < 3; i++) arg_q[i] <= '0;
            timeout_q  <= '0;
            cnt_q      <= '0;
            reply_q    <= '0;
            overrun_q  <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            arg_q      <= arg_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
            reply_q    <= reply_d;
            overrun_q  <= overrun_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
        end
    end

    // EXEC drives fresh values straight from the argument bytes; they are held afterwards
    assign exec_reg_wr = (state_q == StExec) && (op_q == OpRegWr);
    assign exec_reg_rd = (state_q == StExec) && (op_q == OpRegRd);
    assign exec_ram_wr = (state_q == StExec) && (op_q == OpRamWr);

    assign dsp_reg_address      = (exec_reg_wr || exec_reg_rd) ? arg_q[0] : reg_addr_q;
    assign dsp_reg_data_in      = exec_reg_wr ? arg_q[1] : reg_data_q;
    assign dsp_reg_write_enable = exec_reg_wr;
    assign ram_address          = exec_ram_wr ? {arg_q[0], arg_q[1]} : ram_addr_q;
    assign ram_data             = exec_ram_wr ? arg_q[2] : ram_data_q;
    assign ram_write_enable     = exec_ram_wr;
    assign dsp_reset            = (state_q == StRst);
    assign tx_write             = (state_q == StSend) && tx_ready;
    assign tx_byte              = reply_q;
    assign overrun              = overrun_q;
    assign busy                 = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Self-checking bench for uart_cmd_bridge: directed scenarios plus randomized commands
// checked against a command-level model of replies and side effects.
module tb_uart_cmd_bridge;

    localparam int unsigned Timeout = 200;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_uart_byte = 8'h00;
    logic        in_uart_byte_ready = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_write;
    logic        tx_ready = 1'b1;
    logic [7:0]  dsp_reg_address;
    logic [7:0]  dsp_reg_data_in;
    logic        dsp_reg_write_enable;
    logic [7:0]  dsp_reg_data_out;
    logic [15:0] ram_address;
    logic [7:0]  ram_data;
    logic        ram_write_enable;
    logic        dsp_reset;
    logic        overrun;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_cyc = 0;
    logic lat_mode = 1'b0;
    logic [7:0] regfile [256];

    logic [15:0] dsp_wr_q[$];
    int          dsp_wr_cyc[$];
    logic [23:0] ram_wr_q[$];
    logic [7:0]  tx_q[$];
    int          tx_cyc[$];
    int          rst_len_q[$];
    int          rst_run = 0;

    uart_cmd_bridge #(
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_uart_byte(in_uart_byte),
        .in_uart_byte_ready(in_uart_byte_ready),
        .tx_byte(tx_byte),
        .tx_write(tx_write),
        .tx_ready(tx_ready),
        .dsp_reg_address(dsp_reg_address),
        .dsp_reg_data_in(dsp_reg_data_in),
        .dsp_reg_write_enable(dsp_reg_write_enable),
        .dsp_reg_data_out(dsp_reg_data_out),
        .ram_address(ram_address),
        .ram_data(ram_data),
        .ram_write_enable(ram_write_enable),
        .dsp_reset(dsp_reset),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // In latency mode the read data changes every cycle, so the reply pins the sample cycle
    assign dsp_reg_data_out = regfile[dsp_reg_address] ^ (lat_mode ? cyc[7:0] : 8'h00);

    always @(negedge clock) begin
        if (dsp_reg_write_enable) begin
            dsp_wr_q.push_back({dsp_reg_address, dsp_reg_data_in});
            dsp_wr_cyc.push_back(cyc);
        end
        if (ram_write_enable) ram_wr_q.push_back({ram_address, ram_data});
        if (dsp_reg_write_enable || ram_write_enable) begin
            n_checks++;
            if (dsp_reg_write_enable && ram_write_enable) begin
                n_fail++;
                $display("FAIL write_exclusive: both strobes high, required at most one");
            end
        end
        if (tx_write) begin
            tx_q.push_back(tx_byte);
            tx_cyc.push_back(cyc);
        end
        if (dsp_reset) rst_run++;
        else if (rst_run != 0) begin
            rst_len_q.push_back(rst_run);
            rst_run = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        dsp_wr_q.delete();
        dsp_wr_cyc.delete();
        ram_wr_q.delete();
        tx_q.delete();
        tx_cyc.delete();
        rst_len_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        in_uart_byte       = b;
        in_uart_byte_ready = 1'b1;
        last_cyc           = cyc;
        @(negedge clock);
        in_uart_byte_ready = 1'b0;
    endtask

    task automatic send_at(input logic [7:0] b, input int target);
        while (cyc < target) @(negedge clock);
        in_uart_byte       = b;
        in_uart_byte_ready = 1'b1;
        last_cyc           = cyc;
        @(negedge clock);
        in_uart_byte_ready = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({tx_byte, tx_write, dsp_reg_address, dsp_reg_data_in, dsp_reg_write_enable,
             ram_address, ram_data, ram_write_enable, dsp_reset, overrun, busy} !== 54'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got tx=%h addr=%h data=%h ram=%h/%h busy=%b ovr=%b, required all 0",
                     tx_byte, dsp_reg_address, dsp_reg_data_in, ram_address, ram_data, busy, overrun);
        end
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_reg_wr();
        bit ok;
        clear_obs();
        tx_ready = 1'b1;
        send_byte(8'h01);
        send_byte(8'h4C);
        send_byte(8'h3F);
        wait_idle(ok);
        n_checks++;
        if (!ok || dsp_wr_q.size() != 1 || dsp_wr_q[0] !== 16'h4C3F) begin
            n_fail++;
            $display("FAIL reg_wr_strobe: got %0d strobes first=%h, required 1 of 4c3f",
                     dsp_wr_q.size(), dsp_wr_q.size() ? dsp_wr_q[0] : 16'h0);
        end
        n_checks++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'hAA || tx_cyc[0] != last_cyc + 2) begin
            n_fail++;
            $display("FAIL reg_wr_reply: got %0d replies first=%h, required one aa at cycle %0d",
                     tx_q.size(), tx_q.size() ? tx_q[0] : 8'h0, last_cyc + 2);
        end
        n_checks++;
        if (dsp_wr_cyc.size() != 1 || dsp_wr_cyc[0] != last_cyc + 1) begin
            n_fail++;
            $display("FAIL reg_wr_latency: got strobe cycle %0d required %0d",
                     dsp_wr_cyc.size() ? dsp_wr_cyc[0] : -1, last_cyc + 1);
        end
        n_checks++;
        if ({dsp_reg_address, dsp_reg_data_in} !== 16'h4C3F || ram_wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL reg_wr_hold: got %h/%h ram_writes=%0d, required 4c/3f and 0",
                     dsp_reg_address, dsp_reg_data_in, ram_wr_q.size());
        end
    endtask

    task automatic test_reg_rd();
        bit ok;
        clear_obs();
        lat_mode       = 1'b0;
        regfile[8'h5D] = 8'h81;
        send_byte(8'h02);
        send_byte(8'h5D);
        wait_idle(ok);
        n_checks++;
        if (!ok || tx_q.size() != 1 || tx_q[0] !== 8'h81 || tx_cyc[0] != last_cyc + 4) begin
            n_fail++;
            $display("FAIL reg_rd_reply: got %0d replies first=%h, required one 81 at cycle %0d",
                     tx_q.size(), tx_q.size() ? tx_q[0] : 8'h0, last_cyc + 4);
        end
        n_checks++;
        if (dsp_wr_q.size() != 0 || ram_wr_q.size() != 0 || dsp_reg_address !== 8'h5D) begin
            n_fail++;
            $display("FAIL reg_rd_side: got writes %0d/%0d addr=%h, required 0/0 and 5d",
                     dsp_wr_q.size(), ram_wr_q.size(), dsp_reg_address);
        end
    endtask

    task automatic test_ram_wr();
        bit ok;
        clear_obs();
        send_byte(8'h03);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        wait_idle(ok);
        n_checks++;
        if (!ok || ram_wr_q.size() != 1 || ram_wr_q[0] !== 24'h123456 || dsp_wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL ram_wr_strobe: got %0d strobes first=%h, required 1 of 123456",
                     ram_wr_q.size(), ram_wr_q.size() ? ram_wr_q[0] : 24'h0);
        end
        n_checks++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'hAA) begin
            n_fail++;
            $display("FAIL ram_wr_reply: got %0d replies first=%h, required one aa",
                     tx_q.size(), tx_q.size() ? tx_q[0] : 8'h0);
        end
    endtask

    task automatic test_dsp_rst();
        bit ok;
        clear_obs();
        send_byte(8'h04);
        wait_idle(ok);
        n_checks++;
        if (!ok || rst_len_q.size() != 1 || rst_len_q[0] != 16) begin
            n_fail++;
            $display("FAIL dsp_rst_len: got %0d pulses first=%0d, required one of 16 cycles",
                     rst_len_q.size(), rst_len_q.size() ? rst_len_q[0] : -1);
        end
        n_checks++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'hAA || tx_cyc[0] != last_cyc + 18) begin
            n_fail++;
            $display("FAIL dsp_rst_reply: got %0d replies first=%h, required one aa at cycle %0d",
                     tx_q.size(), tx_q.size() ? tx_q[0] : 8'h0, last_cyc + 18);
        end
    endtask

    task automatic test_nak_ping();
        bit ok;
        clear_obs();
        send_byte(8'h7F);
        wait_idle(ok);
        n_checks++;
        if (!ok || tx_q.size() != 1 || tx_q[0] !== 8'hEE || tx_cyc[0] != last_cyc + 2
            || dsp_wr_q.size() != 0 || ram_wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL nak_reply: got %0d replies first=%h, required one ee, no writes",
                     tx_q.size(), tx_q.size() ? tx_q[0] : 8'h0);
        end
        clear_obs();
        send_byte(8'h05);
        wait_idle(ok);
        n_checks++;
        if (!ok || tx_q.size() != 1 || tx_q[0] !== 8'h5A) begin
            n_fail++;
            $display("FAIL ping_reply: got %0d replies first=%h, required one 5a",
                     tx_q.size(), tx_q.size() ? tx_q[0] : 8'h0);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int rise;
        clear_obs();
        tx_ready = 1'b0;
        send_byte(8'h05);
        repeat (500) @(negedge clock);
        n_checks++;
        if (tx_q.size() != 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_hold: got %0d sends busy=%b, required 0 and 1",
                     tx_q.size(), busy);
        end
        tx_ready = 1'b1;
        rise     = cyc;
        wait_idle(ok);
        n_checks++;
        if (!ok || tx_q.size() != 1 || tx_q[0] !== 8'h5A || tx_cyc[0] != rise) begin
            n_fail++;
            $display("FAIL backpressure_release: got %0d sends first=%h, required one 5a at %0d",
                     tx_q.size(), tx_q.size() ? tx_q[0] : 8'h0, rise);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int start;
        clear_obs();
        tx_ready = 1'b1;
        lat_mode = 1'b0;
        send_byte(8'h01);
        send_byte(8'h4C);
        repeat (Timeout + 10) @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || tx_q.size() != 0 || dsp_wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_abort: got busy=%b replies=%0d writes=%0d, required 0/0/0",
                     busy, tx_q.size(), dsp_wr_q.size());
        end
        send_byte(8'h05);
        wait_idle(ok);
        n_checks++;
        if (!ok || tx_q.size() != 1 || tx_q[0] !== 8'h5A) begin
            n_fail++;
            $display("FAIL timeout_next: got %0d replies first=%h, required one 5a",
                     tx_q.size(), tx_q.size() ? tx_q[0] : 8'h0);
        end
        // One cycle before expiry the byte is still an argument
        clear_obs();
        send_byte(8'h02);
        start = last_cyc;
        send_at(8'h33, start + Timeout - 1);
        wait_idle(ok);
        n_checks++;
        if (!ok || tx_q.size() != 1 || tx_q[0] !== regfile[8'h33]) begin
            n_fail++;
            $display("FAIL timeout_edge_arg: got %0d replies first=%h, required one %h",
                     tx_q.size(), tx_q.size() ? tx_q[0] : 8'h0, regfile[8'h33]);
        end
        // On the expiry cycle the byte starts a new command
        clear_obs();
        send_byte(8'h01);
        start = last_cyc;
        send_at(8'h05, start + Timeout);
        wait_idle(ok);
        n_checks++;
        if (!ok || tx_q.size() != 1 || tx_q[0] !== 8'h5A || dsp_wr_q.size() != 0
            || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_edge_new: got %0d replies first=%h writes=%0d ovr=%b, required 5a/0/0",
                     tx_q.size(), tx_q.size() ? tx_q[0] : 8'h0, dsp_wr_q.size(), overrun);
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] op;
        logic [7:0] a [3];
        int nargs, stall, exp_rst;
        logic [7:0] exp_reply;
        logic [15:0] exp_dsp;
        logic [23:0] exp_ram;
        bit want_dsp, want_ram;
        lat_mode = 1'b1;
        for (int it = 0; it < 40; it++) begin
            clear_obs();
            case ($urandom_range(0, 5))
                0: op = 8'h01;
                1: op = 8'h02;
                2: op = 8'h03;
                3: op = 8'h04;
                4: op = 8'h05;
                default: op = 8'(6 + $urandom_range(0, 249));
            endcase
            nargs = (op == 8'h01) ? 2 : (op == 8'h02) ? 1 : (op == 8'h03) ? 3 : 0;
            for (int k = 0; k < 3; k++) a[k] = 8'($urandom);
            stall    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 0;
            tx_ready = (stall == 0);
            send_byte(op);
            for (int k = 0; k < nargs; k++) begin
                repeat ($urandom_range(0, 3)) @(negedge clock);
                send_byte(a[k]);
            end
            want_dsp  = (op == 8'h01);
            want_ram  = (op == 8'h03);
            exp_dsp   = {a[0], a[1]};
            exp_ram   = {a[0], a[1], a[2]};
            exp_rst   = (op == 8'h04) ? 1 : 0;
            case (op)
                8'h01, 8'h03, 8'h04: exp_reply = 8'hAA;
                8'h02:   exp_reply = regfile[a[0]] ^ 8'(last_cyc + 3);
                8'h05:   exp_reply = 8'h5A;
                default: exp_reply = 8'hEE;
            endcase
            if (stall != 0) begin
                repeat (stall) @(negedge clock);
                tx_ready = 1'b1;
            end
            wait_idle(ok);
            n_checks++;
            if (!ok || tx_q.size() != 1 || tx_q[0] !== exp_reply) begin
                n_fail++;
                $display("FAIL random_reply[%0d] op=%h: got %0d replies first=%h, required one %h",
                         it, op, tx_q.size(), tx_q.size() ? tx_q[0] : 8'h0, exp_reply);
            end
            n_checks++;
            if (dsp_wr_q.size() != int'(want_dsp) || (want_dsp && dsp_wr_q[0] !== exp_dsp)
                || ram_wr_q.size() != int'(want_ram) || (want_ram && ram_wr_q[0] !== exp_ram)
                || rst_len_q.size() != exp_rst || (exp_rst == 1 && rst_len_q[0] != 16)) begin
                n_fail++;
                $display("FAIL random_effects[%0d] op=%h: got dsp=%0d ram=%0d rst=%0d, required %0d/%0d/%0d",
                         it, op, dsp_wr_q.size(), ram_wr_q.size(), rst_len_q.size(),
                         want_dsp, want_ram, exp_rst);
            end
        end
        lat_mode = 1'b0;
    endtask

    task automatic test_overrun();
        bit ok;
        clear_obs();
        tx_ready = 1'b0;
        send_byte(8'h05);
        send_byte(8'h01);
        n_checks++;
        if (overrun !== 1'b1 || busy !== 1'b1 || tx_q.size() != 0) begin
            n_fail++;
            $display("FAIL overrun_set: got ovr=%b busy=%b sends=%0d, required 1/1/0",
                     overrun, busy, tx_q.size());
        end
        tx_ready = 1'b1;
        wait_idle(ok);
        repeat (10) @(negedge clock);
        n_checks++;
        if (!ok || tx_q.size() != 1 || tx_q[0] !== 8'h5A || busy !== 1'b0
            || dsp_wr_q.size() != 0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_discard: got %0d replies first=%h busy=%b ovr=%b, required 5a/0/1",
                     tx_q.size(), tx_q.size() ? tx_q[0] : 8'h0, busy, overrun);
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        tx_ready = 1'b1;
        send_byte(8'h04);
        repeat (5) @(negedge clock);
        n_checks++;
        if (dsp_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got dsp_reset=%b required 1", dsp_reset);
        end
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (dsp_reset !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got dsp_reset=%b ovr=%b busy=%b, required 0/0/0",
                     dsp_reset, overrun, busy);
        end
        reset = 1'b0;
        repeat (30) @(negedge clock);
        n_checks++;
        if (tx_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_noreply: got %0d replies busy=%b, required 0/0",
                     tx_q.size(), busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) regfile[i] = 8'($urandom);
        test_reset();
        test_reg_wr();
        test_reg_rd();
        test_ram_wr();
        test_dsp_rst();
        test_nak_ping();
        test_backpressure();
        test_timeout();
        test_random();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
